clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_pkg.sv | 17 +
 rtl/clk_en_acc.sv | 34 +++
 rtl/clk_en_gen.sv | 91 +++++++++
 tb/tb_clk_en_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// Shared types and helpers for the clock-enable generator: FSM states and
// the width of the lock-hold counter.
package clk_en_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } fsm_state_t;

    // The counter only has to reach LOCK_HOLD-1, so LOCK_HOLD 1 or 2 still needs one bit.
    function automatic int hold_cnt_w(input int hold);
        if (hold <= 2) return 1;
        return $clog2(hold);
    endfunction

endpackage

// File: rtl/clk_en_acc.sv
// Single-channel phase accumulator. The carry out of each addition becomes a
// one-cycle enable pulse; clear has priority over hold.
module clk_en_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             hold,
    input  logic [ACC_W-1:0] step,
    output logic             cen
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cen <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cen <= 1'b0;
        end else if (hold) begin
            cen <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            cen <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator running from the PLL clock. Channels
// only accumulate once the synchronised lock has been stable for LOCK_HOLD cycles.
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ACC_W     = 16,
    parameter int LOCK_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*ACC_W-1:0] step,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       cen,
    output logic                    ready
);

    localparam int               CNT_W     = hold_cnt_w(LOCK_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LOCK_HOLD - 1);

    logic             lock_meta;
    logic             lock_sync;
    fsm_state_t       state;
    fsm_state_t       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             run_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            ready    <= (state_nxt == RUN);
        end
    end

    // Losing lock overrides every state, including the HOLD countdown.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (!lock_sync) begin
            state_nxt    = WAIT_LOCK;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = HOLD_LOAD;
                end
                HOLD: begin
                    if (hold_cnt == '0) state_nxt = RUN;
                    else                hold_cnt_nxt = hold_cnt - CNT_W'(1);
                end
                RUN:     state_nxt = RUN;
                default: state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // Accumulators clear on the same edge that the lock drop is seen.
    assign run_go = (state == RUN) && lock_sync;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_acc #(
            .ACC_W(ACC_W)
        ) u_acc (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (!run_go),
            .hold  (!ch_en[i]),
            .step  (step[i*ACC_W +: ACC_W]),
            .cen   (cen[i])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: a cycle model predicts {ready, cen} from lock run
// lengths and per-channel phase arithmetic; a negedge monitor compares.
module tb_clk_en_gen;

    localparam int          NUM_CH    = 4;
    localparam int          ACC_W     = 16;
    localparam int          LOCK_HOLD = 16;
    localparam longint      MODULUS   = longint'(1) << ACC_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    pll_locked = 1'b0;
    logic [NUM_CH*ACC_W-1:0] step = '0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic [NUM_CH-1:0]       cen;
    logic                    ready;

    int checks = 0;
    int failures = 0;

    clk_en_gen #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .LOCK_HOLD(LOCK_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .step      (step),
        .ch_en     (ch_en),
        .cen       (cen),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Reference model. rl_a/rl_b are the lengths of the unbroken run of
    // high lock samples ending one and two edges ago; the synchroniser makes
    // the DUT act on the lock seen two edges earlier.
    logic [NUM_CH:0]  exp_q[$];
    int               rl_a = 0;
    int               rl_b = 0;
    int               r_m;
    longint           phase[NUM_CH];
    longint           sum_m;
    logic [NUM_CH:0]  e_word;

    always @(posedge clk) begin
        if (!rst_n) begin
            rl_a = 0;
            rl_b = 0;
            for (int i = 0; i < NUM_CH; i++) phase[i] = 0;
            exp_q.push_back('0);
        end else begin
            r_m  = rl_b;
            rl_b = rl_a;
            rl_a = pll_locked ? rl_a + 1 : 0;
            e_word = '0;
            e_word[NUM_CH] = (r_m >= LOCK_HOLD + 1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_m >= LOCK_HOLD + 2) begin
                    if (ch_en[i]) begin
                        sum_m     = phase[i] + longint'(step[i*ACC_W +: ACC_W]);
                        e_word[i] = (sum_m >= MODULUS);
                        phase[i]  = sum_m % MODULUS;
                    end
                end else begin
                    phase[i] = 0;
                end
            end
            exp_q.push_back(e_word);
        end
    end

    logic [NUM_CH:0] e_mon;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            check_eq("ready_cen", {ready, cen}, e_mon);
        end
    end

    task automatic wait_ready(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ready) return;
        end
        cyc = -1;
    endtask

    initial begin
        int cyc;
        int first[NUM_CH];
        int cnt[NUM_CH];
        int gap_cnt;
        int last2;
        int bad_gap;
        bit seen_low;

        pll_locked = 1'b1;
        ch_en      = '1;
        step       = {16'hFFFF, 16'h1555, 16'h4000, 16'h8000};
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ready", ready, 0);
        check_eq("reset_cen", cen, 0);

        // Lock high throughout reset still needs full qualification.
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk);
        wait_ready(200, cyc);
        check_eq("ready_latency", cyc, LOCK_HOLD + 3);

        for (int i = 0; i < NUM_CH; i++) first[i] = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++)
                if (cen[i] && first[i] == 0) first[i] = n;
        end
        check_eq("first_pulse_ch0", first[0], 2);
        check_eq("first_pulse_ch1", first[1], 4);
        check_eq("first_pulse_ch2", first[2], 13);
        check_eq("first_pulse_ch3", first[3], 2);

        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #2;
            ch_en = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    case ($urandom_range(0, 3))
                        0:       step[i*ACC_W +: ACC_W] = '0;
                        1:       step[i*ACC_W +: ACC_W] = '1;
                        default: step[i*ACC_W +: ACC_W] = ACC_W'($urandom);
                    endcase
                end
            end
        end

        // Five-cycle enable gap on channel 0 at half rate.
        @(posedge clk); #2;
        ch_en = '1;
        step[0 +: ACC_W] = 16'h8000;
        repeat (10) @(posedge clk);
        #2 ch_en[0] = 1'b0;
        @(negedge clk);
        gap_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            gap_cnt += int'(cen[0]);
        end
        ch_en[0] = 1'b1;
        check_eq("gap_pulses", gap_cnt, 0);
        gap_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            gap_cnt += int'(cen[0]);
        end
        check_eq("resume_pulses", gap_cnt, 4);

        // One-cycle lock drop in RUN.
        repeat (5) @(posedge clk);
        #2 pll_locked = 1'b0;
        @(posedge clk); #2 pll_locked = 1'b1;
        seen_low = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!ready && cen == '0) seen_low = 1'b1;
        end
        check_eq("lock_drop_outputs_low", seen_low, 1);
        wait_ready(200, cyc);
        check_eq("relock_latency", cyc, LOCK_HOLD + 1);

        // Asynchronous reset between edges while pulsing.
        repeat (20) @(posedge clk);
        #7 rst_n = 1'b0;
        #1;
        check_eq("async_reset_ready", ready, 0);
        check_eq("async_reset_cen", cen, 0);
        step  = {16'hFFFF, 16'h1555, 16'h4000, 16'h0000};
        ch_en = '1;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk);
        wait_ready(200, cyc);
        check_eq("ready_latency_after_reset", cyc, LOCK_HOLD + 3);

        // Long-term rates over one full accumulator period.
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        last2   = -1;
        bad_gap = 0;
        for (int n = 1; n <= 65536; n++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) cnt[i] += int'(cen[i]);
            if (cen[2]) begin
                if (last2 >= 0 && (n - last2 < 12 || n - last2 > 13)) bad_gap++;
                last2 = n;
            end
        end
        check_eq("count_step_zero", cnt[0], 0);
        check_eq("count_step_4000", cnt[1], 16384);
        check_rng("count_step_1555", cnt[2], 5460, 5462);
        check_eq("count_step_ffff", cnt[3], 65535);
        check_eq("spacing_step_1555", bad_gap, 0);
        check_eq("ready_held", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
